// File: rtl/riscv_fetch_pc_sequencer.sv
// riscv_fetch_pc_sequencer: owns the IF program counter and picks the next fetch PC
// from rollback, unpredicted EX jump, predictor inject or sequential PC+4, kills
// younger front-end stages on redirects and counts prediction outcomes.
// Ports:
//   clk, nreset                  clock, synchronous active-low reset
//   i_stall                      front end frozen, PC holds
//   i_ex_jump/_addr              EX resolved taken jump and its target
//   i_discard_jump               EX jump was already predicted, no redirect
//   i_rollback_jump/_addr        prediction wrong, restore to rollback target
//   i_if_inject/_addr            predictor redirect of the next fetch
//   i_pm_flush                   accepted inject also kills PM
//   o_if_pc, o_if_valid          registered fetch PC and its validity
//   o_flush_front, o_flush_pm    combinational kills (IF/PM/ID, PM only)
//   o_redirect_pend              EX-class redirect buffered across a stall
//   o_cnt_hit/_mispredict/_inject  saturating statistics counters
module riscv_fetch_pc_sequencer #(
  parameter int ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  i_stall,
  input  logic                  i_ex_jump,
  input  logic [ADDR_WIDTH-1:0] i_ex_jump_addr,
  input  logic                  i_discard_jump,
  input  logic                  i_rollback_jump,
  input  logic [ADDR_WIDTH-1:0] i_rollback_addr,
  input  logic                  i_if_inject,
  input  logic [ADDR_WIDTH-1:0] i_if_inject_addr,
  input  logic                  i_pm_flush,
  output logic [ADDR_WIDTH-1:0] o_if_pc,
  output logic                  o_if_valid,
  output logic                  o_flush_front,
  output logic                  o_flush_pm,
  output logic                  o_redirect_pend,
  output logic [CNT_WIDTH-1:0]  o_cnt_hit,
  output logic [CNT_WIDTH-1:0]  o_cnt_mispredict,
  output logic [CNT_WIDTH-1:0]  o_cnt_inject
);
  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pend_addr_q, pend_addr_d, ex_tgt;
  logic [CNT_WIDTH-1:0] cnt_hit_q, cnt_hit_d, cnt_mispredict_q, cnt_mispredict_d;
  logic [CNT_WIDTH-1:0] cnt_inject_q, cnt_inject_d;
  logic valid, ex_evt, hit, inj_ok;
  always_comb begin
    valid = state_q != BOOT;
    // rule 1 or 2: rollback, or an EX jump the predictor did not cover
    ex_evt = valid && (i_rollback_jump || (i_ex_jump && !i_discard_jump));
    ex_tgt = (i_rollback_jump ? i_rollback_addr : i_ex_jump_addr) & ALIGN_MASK;
    // a rollback in the same cycle makes the discard meaningless, so no hit
    hit = state_q == RUN && i_ex_jump && i_discard_jump && !i_rollback_jump;
    // injects only land in a free-running RUN cycle with no EX-class redirect
    inj_ok = state_q == RUN && !i_stall && !ex_evt && i_if_inject;
    state_d = state_q;
    pc_d = pc_q;
    pend_addr_d = pend_addr_q;
    o_flush_front = valid && (state_q == PEND || ex_evt);
    o_flush_pm = inj_ok && i_pm_flush;
    o_redirect_pend = state_q == PEND || (state_q == RUN && i_stall && ex_evt);
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (i_stall) begin
      if (ex_evt) begin
        pend_addr_d = ex_tgt;
        state_d = PEND;
      end
    end else begin
      // a fresh EX-class redirect on the release cycle is younger than the buffered one
      pc_d = ex_evt ? ex_tgt :
             state_q == PEND ? pend_addr_q :
             inj_ok ? (i_if_inject_addr & ALIGN_MASK) : pc_q + ADDR_WIDTH'(4);
      state_d = RUN;
    end
    cnt_hit_d = cnt_hit_q + CNT_WIDTH'(hit && !(&cnt_hit_q));
    cnt_mispredict_d = cnt_mispredict_q + CNT_WIDTH'(ex_evt && !(&cnt_mispredict_q));
    cnt_inject_d = cnt_inject_q + CNT_WIDTH'(inj_ok && !(&cnt_inject_q));
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= BOOT;
      pc_q <= RESET_ADDR & ALIGN_MASK;
      pend_addr_q <= '0;
      cnt_hit_q <= '0;
      cnt_mispredict_q <= '0;
      cnt_inject_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_addr_q <= pend_addr_d;
      cnt_hit_q <= cnt_hit_d;
      cnt_mispredict_q <= cnt_mispredict_d;
      cnt_inject_q <= cnt_inject_d;
    end
  end
  // discard and rollback together is an upstream protocol error
  always_ff @(posedge clk) begin
    if (nreset && valid) assert (!(i_discard_jump && i_rollback_jump));
  end
  assign o_if_pc = pc_q;
  assign o_if_valid = valid;
  assign o_cnt_hit = cnt_hit_q;
  assign o_cnt_mispredict = cnt_mispredict_q;
  assign o_cnt_inject = cnt_inject_q;
endmodule

// File: tb/tb_riscv_fetch_pc_sequencer.sv
// tb_riscv_fetch_pc_sequencer: directed table, corner sequences and random run against a reference model
module tb_riscv_fetch_pc_sequencer;
  localparam int AW = 64;
  localparam int CW = 8;
  localparam int MAXC = (1 << CW) - 1;
  typedef struct {
    string name;
    bit st, ex, di, rb, ij, pm;
    logic [63:0] xa, ra, ia, pc;
    bit va, ff, fp, pd;
    int h, m, i;
  } vec_t;
  logic clk = 0, nreset = 0, stall = 0, ex = 0, disc = 0, rb = 0, inj = 0, pmf = 0;
  logic [AW-1:0] ex_a = '0, rb_a = '0, inj_a = '0;
  logic [AW-1:0] pc;
  logic valid, ff, fpm, pend;
  logic [CW-1:0] c_hit, c_mis, c_inj;
  logic [AW-1:0] s_pc;
  logic s_valid, s_ff, s_fpm, s_pend;
  logic [CW-1:0] s_hit, s_mis, s_inj;
  int passed = 0, total = 0;
  bit m_valid, m_pending;
  logic [63:0] m_pc, m_pa;
  int m_hit, m_mis, m_inj;
  vec_t tbl[19];
  always #5 clk = ~clk;
  riscv_fetch_pc_sequencer #(.ADDR_WIDTH(AW), .RESET_ADDR('0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .nreset(nreset), .i_stall(stall), .i_ex_jump(ex), .i_ex_jump_addr(ex_a),
    .i_discard_jump(disc), .i_rollback_jump(rb), .i_rollback_addr(rb_a),
    .i_if_inject(inj), .i_if_inject_addr(inj_a), .i_pm_flush(pmf),
    .o_if_pc(pc), .o_if_valid(valid), .o_flush_front(ff), .o_flush_pm(fpm),
    .o_redirect_pend(pend), .o_cnt_hit(c_hit), .o_cnt_mispredict(c_mis), .o_cnt_inject(c_inj)
  );
  function automatic logic [63:0] al(logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction
  function automatic int sat(int c, bit inc);
    return (inc && c < MAXC) ? c + 1 : c;
  endfunction
  function automatic vec_t v(string n, bit st, bit x, bit di, bit r, bit ij, bit pm,
                             logic [63:0] xa, logic [63:0] ra, logic [63:0] ia, logic [63:0] p,
                             bit va, bit f, bit fp, bit pd, int h, int m, int i);
    vec_t t;
    t.name = n; t.st = st; t.ex = x; t.di = di; t.rb = r; t.ij = ij; t.pm = pm;
    t.xa = xa; t.ra = ra; t.ia = ia; t.pc = p; t.va = va; t.ff = f; t.fp = fp; t.pd = pd;
    t.h = h; t.m = m; t.i = i;
    return t;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic m_reset();
    m_valid = 0; m_pending = 0; m_pc = '0; m_pa = '0; m_hit = 0; m_mis = 0; m_inj = 0;
  endtask
  task automatic idle();
    stall = 0; ex = 0; disc = 0; rb = 0; inj = 0; pmf = 0;
  endtask
  // one clock cycle: inputs are already driven; compare at negedge, advance model at posedge
  task automatic step();
    bit evt, inj_ok, hit, e_ff, e_fpm, e_pend;
    logic [63:0] tgt;
    evt = m_valid && (rb || (ex && !disc));
    tgt = al(rb ? rb_a : ex_a);
    inj_ok = m_valid && !m_pending && !stall && !evt && inj;
    hit = m_valid && !m_pending && ex && disc && !rb;
    e_ff = m_valid && (m_pending || evt);
    e_fpm = inj_ok && pmf;
    e_pend = m_valid && (m_pending || (stall && evt));
    @(negedge clk);
    s_pc = pc; s_valid = valid; s_ff = ff; s_fpm = fpm; s_pend = pend;
    s_hit = c_hit; s_mis = c_mis; s_inj = c_inj;
    chk("pc", pc, m_pc);
    chk("valid", 64'(valid), 64'(m_valid));
    chk("flush_front", 64'(ff), 64'(e_ff));
    chk("flush_pm", 64'(fpm), 64'(e_fpm));
    chk("redirect_pend", 64'(pend), 64'(e_pend));
    chk("cnt_hit", 64'(c_hit), 64'(m_hit));
    chk("cnt_mispredict", 64'(c_mis), 64'(m_mis));
    chk("cnt_inject", 64'(c_inj), 64'(m_inj));
    @(posedge clk);
    if (!nreset) m_reset();
    else if (!m_valid) m_valid = 1;
    else begin
      m_mis = sat(m_mis, evt);
      m_hit = sat(m_hit, hit);
      m_inj = sat(m_inj, inj_ok);
      if (stall) begin
        if (evt) begin
          m_pending = 1;
          m_pa = tgt;
        end
      end else begin
        m_pc = evt ? tgt : m_pending ? m_pa : inj_ok ? al(inj_a) : m_pc + 64'd4;
        m_pending = 0;
      end
    end
    #1;
  endtask
  initial begin
    tbl[0]  = v("boot_ignore", 0,0,0,0,1,1, 0, 0, 'h900, 'h0,   0,0,0,0, 0,0,0);
    tbl[1]  = v("run_first",   0,0,0,0,0,0, 0, 0, 0,     'h0,   1,0,0,0, 0,0,0);
    tbl[2]  = v("seq4",        0,0,0,0,0,0, 0, 0, 0,     'h4,   1,0,0,0, 0,0,0);
    tbl[3]  = v("inject",      0,0,0,0,1,1, 0, 0, 'h100, 'h8,   1,0,1,0, 0,0,0);
    tbl[4]  = v("inject_pc",   0,0,0,0,0,0, 0, 0, 0,     'h100, 1,0,0,0, 0,0,1);
    tbl[5]  = v("prio_rb",     0,1,0,1,1,1, 'h300, 'h40, 'h200, 'h104, 1,1,0,0, 0,0,1);
    tbl[6]  = v("rb_pc",       0,0,0,0,0,0, 0, 0, 0,     'h40,  1,0,0,0, 0,1,1);
    tbl[7]  = v("discard",     0,1,1,0,0,0, 'h80, 0, 0,  'h44,  1,0,0,0, 0,1,1);
    tbl[8]  = v("disc_pc",     0,0,0,0,0,0, 0, 0, 0,     'h48,  1,0,0,0, 1,1,1);
    tbl[9]  = v("stall_ex",    1,1,0,0,0,0, 'h500, 0, 0, 'h4c,  1,1,0,1, 1,1,1);
    tbl[10] = v("stall2",      1,0,0,0,0,0, 0, 0, 0,     'h4c,  1,1,0,1, 1,2,1);
    tbl[11] = v("stall3",      1,0,0,0,0,0, 0, 0, 0,     'h4c,  1,1,0,1, 1,2,1);
    tbl[12] = v("release",     0,0,0,0,0,0, 0, 0, 0,     'h4c,  1,1,0,1, 1,2,1);
    tbl[13] = v("pend_pc",     0,0,0,0,0,0, 0, 0, 0,     'h500, 1,0,0,0, 1,2,1);
    tbl[14] = v("inj_align",   0,0,0,0,1,0, 0, 0, 'h123, 'h504, 1,0,0,0, 1,2,1);
    tbl[15] = v("align_pc",    0,0,0,0,0,0, 0, 0, 0,     'h120, 1,0,0,0, 1,2,2);
    tbl[16] = v("stall_inj",   1,0,0,0,1,1, 0, 0, 'h700, 'h124, 1,0,0,0, 1,2,2);
    tbl[17] = v("stall_held",  0,0,0,0,0,0, 0, 0, 0,     'h124, 1,0,0,0, 1,2,2);
    tbl[18] = v("seq_after",   0,0,0,0,0,0, 0, 0, 0,     'h128, 1,0,0,0, 1,2,2);
    m_reset();
    nreset = 0;
    repeat (2) @(posedge clk);
    #1;
    nreset = 1;
    for (int k = 0; k < 19; k++) begin
      stall = tbl[k].st; ex = tbl[k].ex; disc = tbl[k].di; rb = tbl[k].rb;
      inj = tbl[k].ij; pmf = tbl[k].pm; ex_a = tbl[k].xa; rb_a = tbl[k].ra; inj_a = tbl[k].ia;
      step();
      chk({tbl[k].name, "_pc"}, s_pc, tbl[k].pc);
      chk({tbl[k].name, "_valid"}, 64'(s_valid), 64'(tbl[k].va));
      chk({tbl[k].name, "_ff"}, 64'(s_ff), 64'(tbl[k].ff));
      chk({tbl[k].name, "_fpm"}, 64'(s_fpm), 64'(tbl[k].fp));
      chk({tbl[k].name, "_pend"}, 64'(s_pend), 64'(tbl[k].pd));
      chk({tbl[k].name, "_cnt_hit"}, 64'(s_hit), 64'(tbl[k].h));
      chk({tbl[k].name, "_cnt_mis"}, 64'(s_mis), 64'(tbl[k].m));
      chk({tbl[k].name, "_cnt_inj"}, 64'(s_inj), 64'(tbl[k].i));
    end
    idle();
    inj = 1; inj_a = '1;
    step();
    idle();
    step();
    chk("wrap_top", s_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("wrap_zero", s_pc, 64'h0);
    stall = 1; rb = 1; rb_a = 'h600;
    step();
    rb = 0;
    step();
    chk("midpend_pend", 64'(s_pend), 64'd1);
    nreset = 0;
    step();
    nreset = 1; stall = 0;
    step();
    chk("midpend_rst_pc", s_pc, 64'h0);
    chk("midpend_rst_pend", 64'(s_pend), 64'd0);
    chk("midpend_rst_valid", 64'(s_valid), 64'd0);
    rb = 1; rb_a = 'h40;
    repeat (260) step();
    chk("sat_mis", 64'(s_mis), 64'(MAXC));
    step();
    chk("sat_mis_hold", 64'(s_mis), 64'(MAXC));
    idle();
    for (int k = 0; k < 3000; k++) begin
      nreset = ($urandom % 300) != 0;
      stall = ($urandom % 10) < 3;
      ex = ($urandom % 4) == 0;
      disc = ex && ($urandom % 2);
      rb = !disc && ($urandom % 8) == 0;
      inj = ($urandom % 3) == 0;
      pmf = $urandom % 2;
      ex_a = {$urandom, $urandom};
      rb_a = {$urandom, $urandom};
      inj_a = {$urandom, $urandom};
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
